// File: rtl/mem2reg_pkg.sv
// Shared types and default sizes for the memory-to-register block loader.
package mem2reg_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int NREG_DEF   = 8;
  localparam int REG_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;
endpackage

// File: rtl/mem2reg_loader_rd_lat_pipe.sv
// Valid+tag delay line matching the memory read latency; the output stage
// flags the cycle in which mem_douta belongs to the tagged register.
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag
);
  logic [RD_LAT-1:0] vld;
  logic [TAG_W-1:0]  tag [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      tag[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_vld = vld[RD_LAT-1];
  assign out_tag = tag[RD_LAT-1];
endmodule

// File: rtl/mem2reg_loader.sv
// Block-read engine: copies `count` consecutive memory words into an
// 8-entry register file, compensating for a fixed memory read latency.
module mem2reg_loader
  import mem2reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [REG_IDX_W-1:0] dst_reg,
  input  logic [3:0]           count,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_ena,
  output logic                 mem_wea,
  output logic [ADDR_W-1:0]    mem_addra,
  input  logic [DATA_W-1:0]    mem_douta,
  input  logic [REG_IDX_W-1:0] rd_sel,
  output logic [DATA_W-1:0]    rd_data,
  output state_e               state_dbg
);
  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  // Handshake: start is a one-cycle request honoured only in IDLE; done is a
  // one-cycle completion pulse; busy covers every cycle a write may still land.
  state_e               state;
  logic [ADDR_W-1:0]    addr;
  logic [REG_IDX_W-1:0] reg_idx;
  logic [REG_IDX_W-1:0] issue_tag;
  logic [3:0]           remain;
  logic [1:0]           drain_cnt;
  logic                 wr_vld;
  logic [REG_IDX_W-1:0] wr_tag;
  logic [DATA_W-1:0]    regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_ena   <= 1'b0;
      mem_addra <= '0;
      issue_tag <= '0;
      addr      <= '0;
      reg_idx   <= '0;
      remain    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != 4'd0) begin
              mem_ena   <= 1'b1;
              mem_addra <= base_addr;
              issue_tag <= dst_reg;
              addr      <= base_addr + 1'b1;
              reg_idx   <= dst_reg + 1'b1;
              remain    <= count - 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          // remain counts issues still owed after the one on the bus now
          if (remain == 4'd0) begin
            mem_ena   <= 1'b0;
            drain_cnt <= DRAIN_INIT;
            state     <= DRAIN;
          end else begin
            mem_addra <= addr;
            issue_tag <= reg_idx;
            addr      <= addr + 1'b1;
            reg_idx   <= reg_idx + 1'b1;
            remain    <= remain - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (REG_IDX_W)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (mem_ena),
    .in_tag  (issue_tag),
    .out_vld (wr_vld),
    .out_tag (wr_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_vld) begin
      regs[wr_tag] <= mem_douta;
    end
  end

  assign rd_data   = regs[rd_sel];
  assign mem_wea   = 1'b0;
  assign state_dbg = state;
endmodule
